// File: rtl/cordic_fixedpoint_phase_addr_search.sv
// -----------------------------------------------------------------------------
// cordic_fixedpoint_phase_addr_search
//
// Sequential phase-address search placed ahead of the CORDIC rotator. A signed
// phase is accepted, reduced to a saturated magnitude plus sign, and a binary
// search over a programmable ascending threshold table C[0..DEPTH-1] finds the
// largest k with C[k] <= |phase|. The result address, the residual
// (|phase| - C[k], clamped at 0) and the sign are presented with a
// valid/ready handshake.
//
// Ports:
//   iClk, iReset            clock, synchronous active-high reset
//   iPhase, iValid, oReady  input phase handshake (oReady high only in IDLE)
//   oAddr, oResidual, oSign result payload, held stable while oValid is high
//   oValid, iReady          result handshake
//   iTbl_wr/addr/data       threshold table write port (honoured only in IDLE)
//   oTbl_err                one-cycle pulse after a write is dropped
// -----------------------------------------------------------------------------
module cordic_fixedpoint_phase_addr_search #(
   parameter int PHASE_W = 22,
   parameter int ADDR_W  = 4
) (
   input  logic                 iClk,
   input  logic                 iReset,
   input  logic [PHASE_W-1:0]   iPhase,
   input  logic                 iValid,
   output logic                 oReady,
   output logic [ADDR_W-1:0]    oAddr,
   output logic [PHASE_W-2:0]   oResidual,
   output logic                 oSign,
   output logic                 oValid,
   input  logic                 iReady,
   input  logic                 iTbl_wr,
   input  logic [ADDR_W-1:0]    iTbl_addr,
   input  logic [PHASE_W-2:0]   iTbl_data,
   output logic                 oTbl_err
);

   localparam int MAG_W = PHASE_W - 1;
   localparam int DEPTH = 1 << ADDR_W;

   // RESID is the extra edge that registers the residual once the address is final.
   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SEARCH = 2'd1,
      RESID  = 2'd2,
      DONE   = 2'd3
   } state_t;

   state_t              state_r;
   logic [MAG_W-1:0]    tbl_r [DEPTH];
   logic [MAG_W-1:0]    absVal_r;
   logic [ADDR_W-1:0]   bitMask_r;     // one-hot search bit pointer

   logic [MAG_W-1:0]    phaseNegLow_s;
   logic [MAG_W-1:0]    phaseAbs_s;
   logic [ADDR_W-1:0]   trialAddr_s;
   logic                trialHit_s;
   logic [MAG_W-1:0]    residTbl_s;

   // Saturated magnitude of the incoming phase; the most negative code maps to full scale.
   always_comb begin
      phaseNegLow_s = ~iPhase[MAG_W-1:0] + {{(MAG_W-1){1'b0}}, 1'b1};
      phaseAbs_s    = iPhase[MAG_W-1:0];
      if (iPhase[PHASE_W-1]) begin
         if (iPhase[MAG_W-1:0] == {MAG_W{1'b0}}) begin
            phaseAbs_s = {MAG_W{1'b1}};
         end else begin
            phaseAbs_s = phaseNegLow_s;
         end
      end else begin
         phaseAbs_s = iPhase[MAG_W-1:0];
      end
   end

   // Current search trial and the table entry selected by the final address.
   always_comb begin
      trialAddr_s = oAddr | bitMask_r;
      trialHit_s  = (tbl_r[trialAddr_s] <= absVal_r);
      residTbl_s  = tbl_r[oAddr];
   end

   // Control FSM, table storage and all registered outputs.
   always_ff @(posedge iClk) begin
      if (iReset) begin
         state_r   <= IDLE;
         absVal_r  <= {MAG_W{1'b0}};
         bitMask_r <= {ADDR_W{1'b0}};
         oReady    <= 1'b1;
         oValid    <= 1'b0;
         oAddr     <= {ADDR_W{1'b0}};
         oResidual <= {MAG_W{1'b0}};
         oSign     <= 1'b0;
         oTbl_err  <= 1'b0;
         for (int k = 0; k < DEPTH; k++) begin
            tbl_r[k] <= {MAG_W{1'b0}};
         end
      end else begin
         // Writes only land in IDLE so a running search sees a frozen table.
         oTbl_err <= 1'b0;
         if (iTbl_wr) begin
            if (state_r == IDLE) begin
               tbl_r[iTbl_addr] <= iTbl_data;
            end else begin
               oTbl_err <= 1'b1;
            end
         end

         case (state_r)
            IDLE: begin
               if (iValid) begin
                  absVal_r  <= phaseAbs_s;
                  oSign     <= iPhase[PHASE_W-1];
                  oAddr     <= {ADDR_W{1'b0}};
                  bitMask_r <= {{(ADDR_W-1){1'b0}}, 1'b1} << (ADDR_W - 1);
                  oReady    <= 1'b0;
                  state_r   <= SEARCH;
               end
            end
            SEARCH: begin
               if (trialHit_s) begin
                  oAddr <= trialAddr_s;
               end
               bitMask_r <= bitMask_r >> 1;
               if (bitMask_r[0]) begin
                  state_r <= RESID;
               end
            end
            RESID: begin
               // Only C[0] can exceed the magnitude, because address 0 is the fallback.
               if (residTbl_s > absVal_r) begin
                  oResidual <= {MAG_W{1'b0}};
               end else begin
                  oResidual <= absVal_r - residTbl_s;
               end
               oValid  <= 1'b1;
               state_r <= DONE;
            end
            DONE: begin
               if (iReady) begin
                  oValid  <= 1'b0;
                  oReady  <= 1'b1;
                  state_r <= IDLE;
               end
            end
            default: begin
               oValid  <= 1'b0;
               oReady  <= 1'b1;
               state_r <= IDLE;
            end
         endcase
      end
   end

endmodule
